// File: rtl/ili9341_spi_rx.sv
// SPI mode-0 responder for the ILI9341 4-wire link: deframes tagged bytes into a
// small FIFO drained over a Wishbone-style register port, and returns a host byte on MISO.
module ili9341_spi_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic [7:0] ADR_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic       RTY_O,
  output logic [7:0] DAT_O,
  output logic       dataAvail,
  input  logic       chipSelect,
  input  logic       sck,
  input  logic       mosi,
  input  logic       dataCmd,
  output logic       miso
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync, r_dc_sync;
  logic       r_sck_d, r_cs_d;
  logic [6:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [7:0] r_tx, r_tx_hold;
  logic       r_push_v;
  logic [8:0] r_push_d;
  logic [8:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic       r_ovf, r_dataAvail;
  logic       r_req, r_we;
  logic [7:0] r_adr, r_wdat;
  logic       r_ack, r_rty;
  logic [7:0] r_dat;

  logic w_sck, w_cs, w_mosi, w_dc;
  logic w_sck_rise, w_sck_fall, w_cs_fall;
  logic w_full, w_empty, w_wr, w_pop, w_ovf_set;
  logic [CW-1:0] w_count_nxt;
  logic [4:0] w_count5;
  logic [2:0] w_cnt_sat;
  logic w_head_dc;
  logic w_ack, w_rty, w_stat_rd, w_hold_wr;
  logic [7:0] w_rdat;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_dc       = r_dc_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = ~w_cs & r_cs_d;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_dc_sync   <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chipSelect};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], dataCmd};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
    end
  end

  // txReg is reloaded on the 8th rise, so the fall that follows it (bitCount 0)
  // must not shift, otherwise the next byte would lose its MSB.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tx     <= '0;
      r_push_v <= 1'b0;
      r_push_d <= '0;
    end else begin
      r_push_v <= 1'b0;
      if (w_cs) begin
        r_bitcnt <= '0;
      end else if (w_cs_fall) begin
        r_bitcnt <= '0;
        r_tx     <= r_tx_hold;
      end else if (w_sck_rise) begin
        r_shift  <= {r_shift[5:0], w_mosi};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_push_v <= 1'b1;
          r_push_d <= {w_dc, r_shift, w_mosi};
          r_tx     <= r_tx_hold;
        end
      end else if (w_sck_fall && r_bitcnt != 3'd0) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign miso = ~w_cs & r_tx[7];

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wr      = r_push_v & (~w_full | w_pop);
  assign w_ovf_set = r_push_v & w_full & ~w_pop;
  assign w_count5  = 5'(r_count);
  assign w_cnt_sat = (w_count5 > 5'd7) ? 3'd7 : w_count5[2:0];
  assign w_head_dc = w_empty ? 1'b0 : r_mem[r_rptr][8];

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge CLK_I) begin
    if (w_wr) r_mem[r_wptr] <= r_push_d;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_dataAvail <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count     <= w_count_nxt;
      r_dataAvail <= (w_count_nxt != '0);
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_ack     = 1'b0;
    w_rty     = 1'b0;
    w_rdat    = '0;
    w_pop     = 1'b0;
    w_stat_rd = 1'b0;
    w_hold_wr = 1'b0;
    if (r_req) begin
      if (!r_we && r_adr == 8'h00) begin
        if (w_empty) begin
          w_rty = 1'b1;
        end else begin
          w_ack  = 1'b1;
          w_pop  = 1'b1;
          w_rdat = r_mem[r_rptr][7:0];
        end
      end else if (!r_we && r_adr == 8'h01) begin
        w_ack     = 1'b1;
        w_stat_rd = 1'b1;
        w_rdat    = {3'b000, r_ovf, w_head_dc, w_cnt_sat};
      end else if (r_adr == 8'h02) begin
        w_ack = 1'b1;
        if (r_we) w_hold_wr = 1'b1;
        else      w_rdat    = r_tx_hold;
      end else begin
        w_ack = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_ack     <= 1'b0;
      r_rty     <= 1'b0;
      r_dat     <= '0;
      r_tx_hold <= '0;
    end else begin
      r_req <= STB_I & ~r_req;
      if (STB_I && !r_req) begin
        r_we   <= WE_I;
        r_adr  <= ADR_I;
        r_wdat <= DAT_I;
      end
      r_ack <= w_ack;
      r_rty <= w_rty;
      r_dat <= w_rdat;
      if (w_hold_wr) r_tx_hold <= r_wdat;
    end
  end

  assign ACK_O     = r_ack;
  assign RTY_O     = r_rty;
  assign DAT_O     = r_dat;
  assign dataAvail = r_dataAvail;
endmodule
